mem_stage: RTL and testbench

- Memory-access stage of the five-stage pipeline. Sits directly downstream of the EX/MEM pipeline register and consumes its ALU result, store data, destination register and control fields.
- Drives a ready/valid data-memory port, generates byte enables and store-data replication, and aligns and extends load data.
- Stalls the pipeline while a memory access is outstanding.
- Registers the write-back payload (the MEM/WB boundary).

---
 rtl/mem_stage_pkg.sv | 29 ++
 rtl/mem_stage_if.sv | 18 +
 rtl/mem_load_align.sv | 17 +
 rtl/mem_stage.sv | 107 ++++++++++
 tb/tb_mem_stage.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared MEM_ctrl bit positions, size codes, FSM states and lane helpers.
package mem_stage_pkg;
  localparam int CTRL_RD  = 0;
  localparam int CTRL_WR  = 1;
  localparam int CTRL_UNS = 2;
  localparam int CTRL_SZ  = 3;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;
  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic [1:0]  off;
    logic [1:0]  size;
    logic        uns;
    logic [4:0]  rd;
    logic        wb;
  } req_t;
  // Size code 11 behaves as a word; halves and words are forced onto their natural lane.
  function automatic logic [1:0] lane_off(input logic [1:0] sz, input logic [1:0] a);
    return sz == SZ_BYTE ? a : sz == SZ_HALF ? {a[1], 1'b0} : 2'b00;
  endfunction
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    return sz == SZ_BYTE ? 1'b0 : sz == SZ_HALF ? a[0] : |a;
  endfunction
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: ready/valid data-memory port between the memory stage and the data memory.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ready, dmem_rdata
  );
  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mem_load_align.sv
// mem_load_align: selects the addressed byte/half of a read word and sign- or zero-extends it.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_uns,
  output logic [31:0] o_data
);
  logic [31:0] w_sh;
  always_comb begin
    w_sh = i_rdata >> {i_off, 3'b000};
    o_data = i_size == SZ_BYTE ? {{24{~i_uns & w_sh[7]}}, w_sh[7:0]} :
             i_size == SZ_HALF ? {{16{~i_uns & w_sh[15]}}, w_sh[15:0]} : i_rdata;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage; drives the data-memory port, stalls while an access is pending,
// and registers the MEM/WB payload. Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUres_in,
  input  logic [31:0] data2_in,
  input  logic [4:0]  rd_in,
  input  logic [4:0]  MEM_ctrl_in,
  input  logic        WB_ctrl_in,
  mem_stage_if.master dmem,
  output logic        mem_stall,
  output logic [31:0] wb_data_out,
  output logic [4:0]  rd_out,
  output logic        WB_ctrl_out,
  output logic        misalign_out
);
  state_e      r_state;
  req_t        r_req;
  req_t        w_req;
  req_t        w_cur;
  logic        w_is_wr;
  logic        w_is_rd;
  logic        w_trap;
  logic        w_op;
  logic        w_wait;
  logic        w_active;
  logic        w_stall;
  logic        w_go;
  logic [31:0] w_ld;
  always_comb begin
    w_is_wr = MEM_ctrl_in[CTRL_WR];
    w_is_rd = MEM_ctrl_in[CTRL_RD] & ~w_is_wr;
    w_req.alu = ALUres_in;
    w_req.size = MEM_ctrl_in[CTRL_SZ +: 2];
    w_req.off = lane_off(w_req.size, ALUres_in[1:0]);
    w_req.we = w_is_wr;
    w_req.uns = MEM_ctrl_in[CTRL_UNS];
    w_req.rd = rd_in;
    w_req.wb = WB_ctrl_in;
    w_req.wdata = w_req.size == SZ_BYTE ? {4{data2_in[7:0]}} :
                  w_req.size == SZ_HALF ? {2{data2_in[15:0]}} : data2_in;
    w_req.be = !w_is_wr ? 4'b0000 :
               w_req.size == SZ_BYTE ? 4'b0001 << w_req.off :
               w_req.size == SZ_HALF ? 4'b0011 << w_req.off : 4'b1111;
`ifdef MEM_MISALIGN_TRAP_EN
    w_trap = (w_is_rd | w_is_wr) & misaligned(w_req.size, ALUres_in[1:0]);
`else
    w_trap = 1'b0;
`endif
    w_op = (w_is_rd | w_is_wr) & ~w_trap;
  end
  // Once issued, the request is replayed from the latch so the port stays stable while stalled.
  assign w_wait   = r_state == S_WAIT;
  assign w_cur    = w_wait ? r_req : w_req;
  assign w_active = w_wait | w_op;
  assign w_stall  = w_active & ~dmem.dmem_ready;
  assign w_go     = rst & w_active;
  assign mem_stall        = rst & w_stall;
  assign dmem.dmem_req    = w_go;
  assign dmem.dmem_we     = w_go & w_cur.we;
  assign dmem.dmem_addr   = w_go ? {w_cur.alu[31:2], 2'b00} : '0;
  assign dmem.dmem_wdata  = w_go ? w_cur.wdata : '0;
  assign dmem.dmem_be     = w_go ? w_cur.be : '0;
  mem_load_align u_align (
    .i_rdata (dmem.dmem_rdata),
    .i_off   (w_cur.off),
    .i_size  (w_cur.size),
    .i_uns   (w_cur.uns),
    .o_data  (w_ld)
  );
  // While stalled the MEM/WB register takes a bubble so the instruction retires exactly once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_req <= '0;
      wb_data_out <= '0;
      rd_out <= '0;
      WB_ctrl_out <= 1'b0;
      misalign_out <= 1'b0;
    end else begin
      r_state <= w_stall ? S_WAIT : S_IDLE;
      if (!w_wait) r_req <= w_req;
      if (w_stall) begin
        wb_data_out <= '0;
        rd_out <= '0;
        WB_ctrl_out <= 1'b0;
        misalign_out <= 1'b0;
      end else if (w_active) begin
        wb_data_out <= w_cur.we ? w_cur.alu : w_ld;
        rd_out <= w_cur.rd;
        WB_ctrl_out <= w_cur.wb;
        misalign_out <= 1'b0;
      end else begin
        wb_data_out <= ALUres_in;
        rd_out <= rd_in;
        WB_ctrl_out <= WB_ctrl_in & ~w_trap;
        misalign_out <= w_trap;
      end
    end
  end
  a_req_hold: assert property (@(posedge clk) disable iff (!rst)
    dmem.dmem_req && !dmem.dmem_ready |=> dmem.dmem_req && $stable(dmem.dmem_addr)
      && $stable(dmem.dmem_we) && $stable(dmem.dmem_be) && $stable(dmem.dmem_wdata));
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage; request and write-back monitors
// compare against expectations pushed by the stimulus driver from an arithmetic model.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] alu_in = '0;
  logic [31:0] d2_in = '0;
  logic [4:0]  rd_in = '0;
  logic [4:0]  ctrl_in = '0;
  logic        wb_in = 1'b0;
  logic        mem_stall;
  logic [31:0] wb_data_out;
  logic [4:0]  rd_out;
  logic        WB_ctrl_out;
  logic        misalign_out;
  mem_stage_if dif();
  mem_stage dut (
    .clk          (clk),
    .rst          (rst),
    .ALUres_in    (alu_in),
    .data2_in     (d2_in),
    .rd_in        (rd_in),
    .MEM_ctrl_in  (ctrl_in),
    .WB_ctrl_in   (wb_in),
    .dmem         (dif),
    .mem_stall    (mem_stall),
    .wb_data_out  (wb_data_out),
    .rd_out       (rd_out),
    .WB_ctrl_out  (WB_ctrl_out),
    .misalign_out (misalign_out)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } req_s;
  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wb;
    logic        mis;
    logic        full;
  } wb_s;
  req_s req_q[$];
  wb_s  wb_q[$];
  wb_s  e_wb;
  int   n_chk = 0;
  int   n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (dif.dmem_req) begin
      if (req_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_req: got addr %h, no request expected at %0t", dif.dmem_addr, $time);
      end else begin
        chk("req_addr", dif.dmem_addr, req_q[0].addr);
        chk("req_we", 32'(dif.dmem_we), 32'(req_q[0].we));
        chk("req_be", 32'(dif.dmem_be), 32'(req_q[0].be));
        if (req_q[0].we) chk("req_wdata", dif.dmem_wdata, req_q[0].wdata);
        if (dif.dmem_ready) void'(req_q.pop_front());
      end
    end
  end
  always @(negedge clk) begin
    if (rst && (WB_ctrl_out || misalign_out)) begin
      if (wb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_wb: got data %h rd %0d, no write-back expected at %0t", wb_data_out, rd_out, $time);
      end else begin
        e_wb = wb_q.pop_front();
        chk("wb_ctrl", 32'(WB_ctrl_out), 32'(e_wb.wb));
        chk("wb_misalign", 32'(misalign_out), 32'(e_wb.mis));
        if (e_wb.full) begin
          chk("wb_data", wb_data_out, e_wb.data);
          chk("wb_rd", 32'(rd_out), 32'(e_wb.rd));
        end
      end
    end
  end
  task automatic issue(input logic [31:0] alu, input logic [31:0] d2, input logic [4:0] rd,
                       input logic [4:0] ctrl, input logic wb, input int waits, input logic [31:0] rdata);
    logic        is_wr, is_rd, mem, trap;
    int          sz, k, n;
    logic [31:0] v;
    req_s        r;
    wb_s         w;
    is_wr = ctrl[1];
    is_rd = ctrl[0] && !is_wr;
    sz = int'(ctrl[4:3]);
    trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    trap = (is_wr || is_rd) && ((sz == 1 && alu[0]) || (sz >= 2 && alu[1:0] != 2'b00));
`endif
    mem = (is_wr || is_rd) && !trap;
    k = sz == 0 ? int'(alu[1:0]) : sz == 1 ? 2 * int'(alu[1]) : 0;
    v = rdata >> (8 * k);
    if (sz == 0) begin
      v = v & 32'hFF;
      if (!ctrl[2] && v >= 128) v = v - 256;
    end else if (sz == 1) begin
      v = v & 32'hFFFF;
      if (!ctrl[2] && v >= 32768) v = v - 65536;
    end else v = rdata;
    if (mem) begin
      r.addr = alu & 32'hFFFF_FFFC;
      r.we = is_wr;
      r.wdata = sz == 0 ? d2[7:0] * 32'h0101_0101 : sz == 1 ? d2[15:0] * 32'h0001_0001 : d2;
      r.be = !is_wr ? 4'h0 : sz == 0 ? 4'(1 << k) : sz == 1 ? 4'(3 << k) : 4'hF;
      req_q.push_back(r);
    end
    if (trap) begin
      w.data = alu; w.rd = rd; w.wb = 1'b0; w.mis = 1'b1; w.full = 1'b0;
      wb_q.push_back(w);
    end else if (wb) begin
      w.data = (mem && is_rd) ? v : alu; w.rd = rd; w.wb = 1'b1; w.mis = 1'b0; w.full = 1'b1;
      wb_q.push_back(w);
    end
    alu_in = alu; d2_in = d2; rd_in = rd; ctrl_in = ctrl; wb_in = wb;
    n = mem ? waits : 0;
    for (int c = 0; c <= n; c++) begin
      dif.dmem_ready = mem ? (c == n) : 1'($urandom);
      dif.dmem_rdata = (mem && c == n) ? rdata : $urandom;
      @(negedge clk);
      chk("mem_stall", 32'(mem_stall), 32'(mem && c < n));
      if (c > 0) begin
        chk("bubble_wb", 32'(WB_ctrl_out), 32'd0);
        chk("bubble_rd", 32'(rd_out), 32'd0);
      end
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [1:0] sz;
    logic [4:0] ctrl;
    int t;
    alu_in = 32'h0000_1000; ctrl_in = 5'b10001; wb_in = 1'b1; rd_in = 5'd3;
    dif.dmem_ready = 1'b1; dif.dmem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(dif.dmem_req), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_addr", dif.dmem_addr, 32'd0);
    chk("rst_wb_data", wb_data_out, 32'd0);
    chk("rst_rd", 32'(rd_out), 32'd0);
    chk("rst_wb_ctrl", 32'(WB_ctrl_out), 32'd0);
    chk("rst_misalign", 32'(misalign_out), 32'd0);
    @(posedge clk);
    #1;
    ctrl_in = '0; wb_in = 1'b0;
    rst = 1'b1;
    issue(32'h0000_1003, 32'h0, 5'd1, 5'b00001, 1'b1, 0, 32'h80FF_FF7F);
    issue(32'h0000_2002, 32'h1234_ABCD, 5'd0, 5'b01010, 1'b0, 1, 32'h0);
    issue(32'h0000_4000, 32'h0, 5'd9, 5'b10001, 1'b1, 3, 32'hCAFE_F00D);
    issue(32'hDEAD_BEEF, 32'h0, 5'd5, 5'b00000, 1'b1, 0, 32'h0);
    issue(32'h0000_3001, 32'h0, 5'd6, 5'b10001, 1'b1, 1, 32'h1357_9BDF);
    issue(32'h0000_5006, 32'hFFFF_8001, 5'd4, 5'b01110, 1'b0, 0, 32'h0);
    alu_in = 32'h0000_6000; ctrl_in = 5'b10001; wb_in = 1'b1; rd_in = 5'd7;
    dif.dmem_ready = 1'b0;
    req_q.push_back('{addr: 32'h0000_6000, wdata: 32'h0, be: 4'h0, we: 1'b0});
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_req", 32'(dif.dmem_req), 32'd0);
    chk("mid_rst_stall", 32'(mem_stall), 32'd0);
    chk("mid_rst_be", 32'(dif.dmem_be), 32'd0);
    chk("mid_rst_wb_ctrl", 32'(WB_ctrl_out), 32'd0);
    chk("mid_rst_rd", 32'(rd_out), 32'd0);
    req_q.delete();
    @(posedge clk);
    #1;
    ctrl_in = '0; wb_in = 1'b0;
    rst = 1'b1;
    issue(32'h0000_7002, 32'h0, 5'd11, 5'b01101, 1'b1, 2, 32'h89AB_CDEF);
    for (int i = 0; i < 150; i++) begin
      t = int'($urandom_range(0, 3));
      sz = 2'($urandom);
      ctrl = {sz, 1'($urandom), 2'(t)};
      issue($urandom, $urandom, 5'($urandom_range(1, 31)), ctrl, t < 2, int'($urandom_range(0, 3)), $urandom);
    end
    repeat (3) issue(32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 0, 32'h0);
    chk("req_q_empty", 32'(req_q.size()), 32'd0);
    chk("wb_q_empty", 32'(wb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
